// File: rtl/mole_spawner.sv
// Mole spawner for the whack-a-mole board.
// Spawns pseudo-random moles on a tick interval, caps the number of
// concurrently active moles, and retires moles on timeout or on a hit.
// Each board position is one mole_lane instance in a generate array.

// One board position: up/down flag, lifetime counter and expiry pulse.
module mole_lane #(
  parameter int LIFE_TICKS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tick,
  input  logic hit,
  input  logic spawn,
  output logic on,
  output logic on_nxt,
  output logic expired
);
  localparam int LW = $clog2(LIFE_TICKS + 1);

  logic [LW-1:0] life, life_nxt;
  logic          exp_nxt;

  // Next-state for this slot; a disabled lane clears silently (no expiry).
  always_comb begin
    on_nxt   = on;
    life_nxt = life;
    exp_nxt  = 1'b0;
    if (!en) begin
      on_nxt   = 1'b0;
      life_nxt = '0;
    end else if (spawn) begin
      // a spawn on this slot beats a same-cycle hit
      on_nxt   = 1'b1;
      life_nxt = LW'(LIFE_TICKS);
    end else if (on) begin
      if (hit) begin
        // hit beats a same-cycle expiry, so no pulse here
        on_nxt   = 1'b0;
        life_nxt = '0;
      end else if (tick) begin
        if (life <= LW'(1)) begin
          on_nxt   = 1'b0;
          life_nxt = '0;
          exp_nxt  = 1'b1;
        end else begin
          life_nxt = life - LW'(1);
        end
      end
    end
  end

  // Slot state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on      <= 1'b0;
      life    <= '0;
      expired <= 1'b0;
    end else begin
      on      <= on_nxt;
      life    <= life_nxt;
      expired <= exp_nxt;
    end
  end
endmodule

module mole_spawner #(
  parameter int          NUM_MOLES   = 18,
  parameter int          SPAWN_TICKS = 500,
  parameter int          LIFE_TICKS  = 1000,
  parameter int          MAX_ACTIVE  = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 end_game,
  input  logic                 tick,
  input  logic [NUM_MOLES-1:0] hit,
  output logic [NUM_MOLES-1:0] mole_on,
  output logic [NUM_MOLES-1:0] expired,
  output logic [4:0]           active_count,
  output logic                 running
);
  localparam int SW = $clog2(SPAWN_TICKS + 1);

  typedef enum logic [1:0] {IDLE, RUN, PROBE, STOP} state_t;

  state_t                 state;
  logic [SW-1:0]          spawn_cnt;
  logic [4:0]             cand, cand_init, cand_nxt;
  logic [15:0]            lfsr, lfsr_nxt;
  logic [NUM_MOLES-1:0]   on_nxt, spawn;
  logic [4:0]             cnt_nxt;
  logic                   upd, probe_take;

  // Galois LFSR, right shift; free-running in every state.
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Free-running LFSR register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_nxt;
  end

  // Fold the 5-bit LFSR slice onto 0..NUM_MOLES-1.
  assign cand_init = (lfsr[4:0] >= 5'(NUM_MOLES)) ? lfsr[4:0] - 5'(NUM_MOLES) : lfsr[4:0];
  assign cand_nxt  = (cand == 5'(NUM_MOLES - 1)) ? 5'd0 : cand + 5'd1;

  // Lanes evolve only in a live game; start/end_game clear them instead.
  assign upd        = (state == RUN || state == PROBE) && !start && !end_game;
  assign probe_take = upd && (state == PROBE) && !mole_on[cand];

  for (genvar i = 0; i < NUM_MOLES; i++) begin : g_lane
    assign spawn[i] = probe_take && (cand == 5'(i));
    mole_lane #(.LIFE_TICKS(LIFE_TICKS)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (upd),
      .tick    (tick),
      .hit     (hit[i]),
      .spawn   (spawn[i]),
      .on      (mole_on[i]),
      .on_nxt  (on_nxt[i]),
      .expired (expired[i])
    );
  end

  // Popcount of the next mole vector so the count lands with mole_on.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_MOLES; i++) cnt_nxt = cnt_nxt + 5'(on_nxt[i]);
  end

  // Registered active-mole count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) active_count <= '0;
    else     active_count <= cnt_nxt;
  end

  // Game FSM: spawn timing, probe walk and run/stop control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      spawn_cnt <= '0;
      cand      <= '0;
      running   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            spawn_cnt <= '0;
            running   <= 1'b1;
          end
        end
        RUN: begin
          if (end_game) begin
            state   <= STOP;
            running <= 1'b0;
          end else if (start) begin
            spawn_cnt <= '0;
          end else if (tick) begin
            if (spawn_cnt == SW'(SPAWN_TICKS - 1)) begin
              spawn_cnt <= '0;
              // full board skips this attempt
              if (active_count < 5'(MAX_ACTIVE)) begin
                cand  <= cand_init;
                state <= PROBE;
              end
            end else begin
              spawn_cnt <= spawn_cnt + 1'b1;
            end
          end
        end
        PROBE: begin
          if (end_game) begin
            state   <= STOP;
            running <= 1'b0;
          end else if (start) begin
            state     <= RUN;
            spawn_cnt <= '0;
          end else if (!mole_on[cand]) begin
            state <= RUN;
          end else begin
            // cap below NUM_MOLES guarantees the walk finds a free slot
            cand <= cand_nxt;
          end
        end
        STOP: begin
          if (start && !end_game) begin
            state     <= RUN;
            spawn_cnt <= '0;
            running   <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with SPAWN_TICKS=4, LIFE_TICKS=6,
// MAX_ACTIVE=2; a second instance with long lifetimes exercises the cap.
module tb_mole_spawner;
  logic        clk = 1'b0, rst = 1'b0;
  logic        start = 1'b0, start2 = 1'b0, end_game = 1'b0, tick = 1'b0;
  logic [17:0] hit = '0;
  logic [17:0] mole_on, expired, mole_on2, expired2;
  logic [4:0]  active_count, active_count2;
  logic        running, running2;
  logic [15:0] m_lfsr;
  int          errors = 0, checks = 0;

  mole_spawner #(.SPAWN_TICKS(4), .LIFE_TICKS(6), .MAX_ACTIVE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .end_game(end_game), .tick(tick), .hit(hit),
    .mole_on(mole_on), .expired(expired), .active_count(active_count), .running(running));

  mole_spawner #(.SPAWN_TICKS(4), .LIFE_TICKS(20), .MAX_ACTIVE(2)) u_cap (
    .clk(clk), .rst(rst), .start(start2), .end_game(end_game), .tick(tick), .hit(hit),
    .mole_on(mole_on2), .expired(expired2), .active_count(active_count2), .running(running2));

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction
  function automatic logic [15:0] adv(input logic [15:0] l, input int n);
    logic [15:0] v = l;
    for (int k = 0; k < n; k++) v = step(v);
    return v;
  endfunction
  function automatic int cidx(input logic [15:0] l);
    int c = int'(l[4:0]);
    return (c >= 18) ? c - 18 : c;
  endfunction
  function automatic logic [17:0] bit18(input int i);
    logic [17:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction
  function automatic int nxt(input int i);
    return (i == 17) ? 0 : i + 1;
  endfunction

  // Reference LFSR, independent of the DUT.
  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= step(m_lfsr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  // Start pulse, then expect the first mole 2 clk after the 4th RUN tick.
  task automatic first_spawn(input string tag, output int idx);
    start = 1'b1;
    clk1;
    chk({tag, "_running"}, running, 1);
    chk({tag, "_cleared"}, mole_on, 0);
    chk({tag, "_noexp"}, expired, 0);
    start = 1'b0;
    clk1; clk1; clk1;
    idx = cidx(m_lfsr);
    clk1;
    chk({tag, "_probe_wait"}, mole_on, 0);
    clk1;
    chk({tag, "_spawn"}, mole_on, bit18(idx));
    chk({tag, "_count1"}, active_count, 1);
  endtask

  initial begin
    int a, cb, b2, d, a1, c2, a2;
    logic found;
    logic [15:0] l;
    #2 rst = 1'b1;
    #2;
    chk("rst_mole_on", mole_on, 0);
    chk("rst_expired", expired, 0);
    chk("rst_count", active_count, 0);
    chk("rst_running", running, 0);
    chk("rst_lfsr", dut.lfsr, 16'hACE1);
    @(posedge clk); #1;
    rst  = 1'b0;
    tick = 1'b1;
    clk1;
    chk("idle_running", running, 0);
    chk("idle_mole_on", mole_on, 0);

    // 1: first spawn at LFSR-derived index
    first_spawn("t1", a);

    // 2: natural expiry 6 ticks after rise, second spawn alongside
    clk1; clk1; clk1;
    cb = cidx(m_lfsr);
    b2 = (cb == a) ? nxt(a) : cb;
    clk1; clk1;
    chk("t2_still_up", mole_on & bit18(a), bit18(a));
    chk("t2_no_early_exp", expired, 0);
    clk1;
    chk("t2_mole_on", mole_on, bit18(b2));
    chk("t2_expired", expired, bit18(a));
    chk("t2_count", active_count, 1);
    clk1;
    chk("t2_exp_one_cycle", expired, 0);

    // 3: hit active mole 2 ticks after spawn, then hit an inactive one
    first_spawn("t3", a);
    clk1; clk1;
    hit = bit18(a);
    clk1;
    chk("t3_hit_clear", mole_on, 0);
    chk("t3_hit_noexp", expired, 0);
    chk("t3_hit_count", active_count, 0);
    hit = bit18(nxt(a));
    clk1;
    chk("t3_miss_mole_on", mole_on, 0);
    chk("t3_miss_count", active_count, 0);
    hit = '0;

    // 5: hit on expiry cycle, end_game, start ignored while end_game
    first_spawn("t5", a);
    clk1; clk1; clk1; clk1; clk1;
    hit = bit18(a);
    clk1;
    chk("t5_hitexp_clear", mole_on & bit18(a), 0);
    chk("t5_hitexp_noexp", expired, 0);
    hit = '0;
    end_game = 1'b1;
    clk1;
    chk("t5_end_mole_on", mole_on, 0);
    chk("t5_end_running", running, 0);
    chk("t5_end_count", active_count, 0);
    chk("t5_end_noexp", expired, 0);
    start = 1'b1;
    clk1;
    chk("t5_start_ignored", running, 0);
    chk("t5_stop_mole_on", mole_on, 0);
    start = 1'b0;
    end_game = 1'b0;
    clk1;
    chk("t5_stop_holds", running, 0);

    // 6: async reset while probing
    first_spawn("t6", a);
    clk1; clk1; clk1; clk1;
    chk("t6_pre_rst", mole_on, bit18(a));
    rst = 1'b1;
    #1;
    chk("t6_rst_mole_on", mole_on, 0);
    chk("t6_rst_running", running, 0);
    chk("t6_rst_count", active_count, 0);
    chk("t6_rst_expired", expired, 0);
    chk("t6_rst_lfsr", dut.lfsr, 16'hACE1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t6_rel_lfsr", dut.lfsr, 16'hACE1);
    chk("t6_rel_running", running, 0);
    clk1;
    chk("t6_idle_running", running, 0);
    chk("t6_idle_mole_on", mole_on, 0);

    // 4a: collision on slot 17 wraps the probe to slot 0
    l = m_lfsr;
    found = 1'b0;
    d = 0;
    for (int k = 0; k < 40000 && !found; k++) begin
      if (cidx(adv(l, 4)) == 17 && cidx(adv(l, 9)) == 17) begin
        found = 1'b1;
        d = k;
      end else begin
        l = step(l);
      end
    end
    chk("t4_seed_search", found, 1);
    if (found) begin
      repeat (d) clk1;
      start = 1'b1;
      clk1;
      start = 1'b0;
      repeat (4) clk1;
      clk1;
      chk("t4_spawn17", mole_on, bit18(17));
      repeat (5) clk1;
      chk("t4_probing", mole_on, bit18(17));
      clk1;
      chk("t4_wrap0", mole_on, bit18(0));
      chk("t4_exp17", expired, bit18(17));
      chk("t4_wrap_count", active_count, 1);
    end

    // 4b: cap of 2 on the long-lifetime instance
    l  = m_lfsr;
    a1 = cidx(adv(l, 4));
    c2 = cidx(adv(l, 9));
    a2 = (c2 == a1) ? nxt(a1) : c2;
    start2 = 1'b1;
    clk1;
    start2 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      clk1;
      chk("t4_cap_le2", ($countones(mole_on2) <= 2), 1);
    end
    chk("t4_cap_mole_on", mole_on2, bit18(a1) | bit18(a2));
    chk("t4_cap_count", active_count2, 2);
    chk("t4_cap_running", running2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Generates the 18-bit `mole_on` vector that the score/miss counter consumes.
- Pseudo-randomly spawns moles at a fixed tick interval and caps the number of concurrently active moles.
- Retires each mole either when its lifetime expires or when it is whacked.
- Stops and clears the board when the downstream counter asserts `end_game`.

Parameters:
- NUM_MOLES, 18, number of mole positions; fixed at 18 for this board.
- SPAWN_TICKS, 500, ticks between spawn attempts; must be >= 1.
- LIFE_TICKS, 1000, ticks a mole stays up if not hit; must be >= 1.
- MAX_ACTIVE, 3, maximum simultaneously active moles; range 1..NUM_MOLES.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, one-cycle pulse; starts or restarts a game.
- end_game, input, 1, level from the score counter; stops the game.
- tick, input, 1, one-cycle timebase enable (e.g. 1 ms).
- hit, input, 18, one-cycle whack pulses per position (debounced switch rising edges).
- mole_on, output, 18, registered active-mole vector.
- expired, output, 18, one-cycle pulse per mole that timed out unhit.
- active_count, output, 5, number of bits set in mole_on.
- running, output, 1, high in RUN or PROBE.

Behaviour:
- Reset values:
  - mole_on=0, expired=0, active_count=0, running=0.
  - FSM=IDLE, spawn counter=0, all lifetime counters=0, LFSR=LFSR_SEED.
- LFSR:
  - 16-bit Galois, mask 16'hB400, shift right.
  - Advances every clk cycle in every state, including IDLE and STOP.
  - Candidate index: c = lfsr[4:0]; if c >= 18 then c-18, else c.
- FSM states: IDLE, RUN, PROBE, STOP.
  - IDLE: outputs held at 0. On `start`: go to RUN; clear spawn counter, lifetimes, mole_on.
  - RUN: on each `tick`, spawn counter increments. When `tick` arrives with counter == SPAWN_TICKS-1:
    - counter returns to 0;
    - if active_count < MAX_ACTIVE: latch candidate index, go to PROBE;
    - otherwise the attempt is skipped and the FSM stays in RUN.
  - PROBE, one candidate per clk:
    - if mole_on[cand]==0: set it next cycle, load its lifetime with LIFE_TICKS, return to RUN;
    - else cand = (cand==17) ? 0 : cand+1 and stay in PROBE.
    - Spawn attempt to mole_on rise: 2 clk minimum, at most 19 clk. No deadlock: MAX_ACTIVE <= 18 guarantees a free slot.
  - STOP: entered from RUN or PROBE when end_game==1.
    - mole_on and lifetimes cleared on the entry clock edge; no expired pulses generated.
    - Leaves to RUN on `start` only when end_game==0. A `start` while end_game==1 is ignored.
  - `start` in RUN or PROBE restarts: all moles cleared, spawn counter zeroed, no expired pulses.
- Lifetimes, active in RUN and PROBE:
  - On `tick`, every active mole's counter decrements.
  - When an active counter goes 1 to 0: mole_on[i] clears and expired[i] pulses for exactly one clk, on the same edge.
- Hits, processed in RUN and PROBE:
  - hit[i] with mole_on[i]==1: mole_on[i] clears next edge; no expired pulse.
  - hit[i] on an inactive mole: ignored; miss counting belongs downstream.
  - Hit and expiry on the same cycle: hit wins, no expired pulse.
  - Hit on the slot being spawned the same cycle: spawn wins; the mole comes up.
- active_count:
  - Registered popcount, updated on the same edge as mole_on.
  - The PROBE decision uses the registered value.
- end_game has priority over spawns, hits and expiries occurring in the same cycle.
- Async rst mid-game returns everything to reset values immediately.

Test Plan:
(All scenarios: SPAWN_TICKS=4, LIFE_TICKS=6, MAX_ACTIVE=2, tick=1 every cycle.)
1. Reset then `start` → first spawn attempt on the 4th tick. One mole_on bit rises 2 clk later, at the index derived from the LFSR. active_count=1.
2. No hits → that mole clears 6 ticks after rising, with a one-cycle expired pulse on the same bit. active_count returns to 0.
3. Hit the active mole 2 ticks after spawn → bit clears next clk, expired stays 0. Then hit an inactive bit → no change.
4. Keep 2 moles active → third spawn attempt skipped; mole_on popcount never exceeds 2. Force candidate collision (preload occupied slot 17) → probe wraps to 0.
5. Hit and expiry on the same mole/cycle → mole clears, expired=0. Assert end_game mid-game → mole_on=0 next clk, running=0. `start` with end_game=1 → stays STOP.
6. Assert rst during PROBE → all outputs 0 asynchronously. After release, LFSR=16'hACE1 and FSM=IDLE.
